// File: rtl/panda_pkg.sv
// Shared constants and writeback request type for the panda integer core.
// Writeback stages build wb_req_t at the default register-file geometry.
package panda_pkg;

  localparam int unsigned WbWidth        = 32;
  localparam int unsigned WbDepth        = 32;
  localparam int unsigned WbAddrW        = $clog2(WbDepth);
  localparam int unsigned MaxWaitDefault = 4;

  typedef struct packed {
    logic [WbAddrW-1:0] addr;
    logic [WbWidth-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/panda_scoreboard.sv
// Pending-destination scoreboard for long-latency ops; RAW/WAW issue stall.
// Set/clear land on the next edge; this cycle's clear is bypassed into the stall.
module panda_scoreboard
  import panda_pkg::*;
#(
  parameter int unsigned Depth = WbDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic [$clog2(Depth)-1:0] issue_rs1_addr_i,
  input  logic [$clog2(Depth)-1:0] issue_rs2_addr_i,
  input  logic                     issue_rs1_used_i,
  input  logic                     issue_rs2_used_i,
  input  logic [$clog2(Depth)-1:0] issue_rd_addr_i,
  input  logic                     issue_rd_we_i,
  input  logic                     issue_long_i,
  input  logic                     clr_vld_i,
  input  logic [$clog2(Depth)-1:0] clr_addr_i,
  output logic                     issue_stall_o,
  output logic [Depth-1:0]         pending_o
);

  logic [Depth-1:0] pending_q;
  logic [Depth-1:0] pending_d;
  logic [Depth-1:0] clr_vec;
  logic [Depth-1:0] set_vec;
  logic [Depth-1:0] eff_pending;
  logic             stall;

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (clr_vld_i) begin
      clr_vec[clr_addr_i] = 1'b1;
    end
    // The register file is write-first, so a register retiring now is already safe to read.
    eff_pending = pending_q & ~clr_vec;
    stall = issue_valid_i &
            ((issue_rs1_used_i & eff_pending[issue_rs1_addr_i]) |
             (issue_rs2_used_i & eff_pending[issue_rs2_addr_i]) |
             (issue_rd_we_i    & eff_pending[issue_rd_addr_i]));
    if (issue_valid_i & ~stall & issue_long_i & issue_rd_we_i &
        (issue_rd_addr_i != '0)) begin
      set_vec[issue_rd_addr_i] = 1'b1;
    end
    // OR-ing set after masking clear lets a re-issue win over a same-cycle retire.
    pending_d    = eff_pending | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign issue_stall_o = stall;
  assign pending_o     = pending_q;

endmodule

// File: rtl/panda_writeback_arbiter.sv
// Register-file write-port arbiter: ALU has priority, long path forced after MaxWait denials.
// Zero-latency combinational grant; hazard stall comes from the scoreboard.
module panda_writeback_arbiter
  import panda_pkg::*;
#(
  parameter int unsigned Width   = WbWidth,
  parameter int unsigned Depth   = WbDepth,
  parameter int unsigned MaxWait = MaxWaitDefault
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic [$clog2(Depth)-1:0] issue_rs1_addr_i,
  input  logic [$clog2(Depth)-1:0] issue_rs2_addr_i,
  input  logic                     issue_rs1_used_i,
  input  logic                     issue_rs2_used_i,
  input  logic [$clog2(Depth)-1:0] issue_rd_addr_i,
  input  logic                     issue_rd_we_i,
  input  logic                     issue_long_i,
  output logic                     issue_stall_o,
  input  logic                     alu_valid_i,
  input  logic [$clog2(Depth)-1:0] alu_rd_addr_i,
  input  logic [Width-1:0]         alu_rd_data_i,
  output logic                     alu_ready_o,
  input  logic                     long_valid_i,
  input  logic [$clog2(Depth)-1:0] long_rd_addr_i,
  input  logic [Width-1:0]         long_rd_data_i,
  output logic                     long_ready_o,
  output logic [$clog2(Depth)-1:0] rd_addr_o,
  output logic [Width-1:0]         rd_data_o,
  output logic                     rd_we_o,
  output logic [Depth-1:0]         pending_o
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

  logic [CntW-1:0] wait_cnt_q;
  logic [CntW-1:0] wait_cnt_d;
  logic            starve;
  logic            alu_rdy;
  logic            long_rdy;
  logic            alu_gnt;
  logic            long_gnt;

  assign starve   = (wait_cnt_q == MaxCnt);
  assign long_rdy = ~alu_valid_i | starve;
  assign alu_rdy  = ~(starve & long_valid_i);
  assign long_gnt = long_valid_i & long_rdy;
  assign alu_gnt  = alu_valid_i & alu_rdy;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (~long_valid_i | long_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxCnt) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // With no grant the ALU inputs still drive the port; rd_we_o qualifies them.
  assign rd_addr_o    = long_gnt ? long_rd_addr_i : alu_rd_addr_i;
  assign rd_data_o    = long_gnt ? long_rd_data_i : alu_rd_data_i;
  assign rd_we_o      = long_gnt | alu_gnt;
  assign alu_ready_o  = alu_rdy;
  assign long_ready_o = long_rdy;

  panda_scoreboard #(
    .Depth (Depth)
  ) u_scoreboard (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid_i),
    .issue_rs1_addr_i (issue_rs1_addr_i),
    .issue_rs2_addr_i (issue_rs2_addr_i),
    .issue_rs1_used_i (issue_rs1_used_i),
    .issue_rs2_used_i (issue_rs2_used_i),
    .issue_rd_addr_i  (issue_rd_addr_i),
    .issue_rd_we_i    (issue_rd_we_i),
    .issue_long_i     (issue_long_i),
    .clr_vld_i        (long_gnt),
    .clr_addr_i       (long_rd_addr_i),
    .issue_stall_o    (issue_stall_o),
    .pending_o        (pending_o)
  );

endmodule

// File: doc/panda_writeback_arbiter.md
# panda_writeback_arbiter

Controller that owns the single write port of the integer register file and shares it between two writeback requesters: the single-cycle ALU path and the long-latency LSU/MDU path. A per-register scoreboard tracks destinations of issued long-latency operations. It stalls issue on RAW and WAW hazards against them, and an anti-starvation counter guarantees the long-latency path is eventually granted. Sits between the issue/writeback stages and the register file.

## Interface
- Width, 32, register data width
- Depth, 32, number of architectural registers; index 0 is x0
- MaxWait, 4, max consecutive cycles the long path waits before forced grant; ≥1
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  instruction at issue
- issue_rs1_addr_i / issue_rs2_addr_i  in  $clog2(Depth)  source registers
- issue_rs1_used_i / issue_rs2_used_i  in  1  source actually read
- issue_rd_addr_i  in  $clog2(Depth)  destination
- issue_rd_we_i  in  1  instruction writes rd
- issue_long_i  in  1  result returns via long path
- issue_stall_o  out  1  hold issue this cycle
- alu_valid_i  in  1  ALU writeback request
- alu_rd_addr_i  in  $clog2(Depth), alu_rd_data_i  in  Width
- alu_ready_o  out  1  ALU writeback accepted
- long_valid_i  in  1  long-path writeback request
- long_rd_addr_i  in  $clog2(Depth), long_rd_data_i  in  Width
- long_ready_o  out  1  long-path writeback accepted
- rd_addr_o  out  $clog2(Depth), rd_data_o  out  Width, rd_we_o  out  1  register file write port
- pending_o  out  Depth  scoreboard state (bit 0 always 0)

## Operation
- Scoreboard: pending[Depth-1:1] flops; bit 0 constant 0.
- Set: issue accepted (issue_valid_i & ~issue_stall_o) with issue_long_i & issue_rd_we_i & rd≠0 sets pending[rd].
- Clear: long_valid_i & long_ready_o clears pending[long_rd_addr_i]. Set wins over clear on the same index in the same cycle.
- Effective pending = pending & ~clear_vec. The register file is write-first, so a register retiring this cycle is readable by issue this cycle.
- issue_stall_o = issue_valid_i & ((rs1_used & eff[rs1]) | (rs2_used & eff[rs2]) | (rd_we & eff[rd])). Purely combinational. x0 never stalls.
- Arbitration: starve = (wait_cnt == MaxWait).
  - long_ready_o = ~alu_valid_i | starve.
  - alu_ready_o = ~(starve & long_valid_i).
  - At most one grant per cycle.
- wait_cnt, width $clog2(MaxWait+1):
  - increments, saturating at MaxWait, when long_valid_i & ~long_ready_o;
  - clears to 0 on a long grant or when long_valid_i is low.
- Write port: the granted requester's addr/data drive rd_addr_o/rd_data_o, with rd_we_o = grant. When there is no grant, rd_we_o=0 and addr/data are the ALU inputs.
- A long writeback to a non-pending rd is still written and the clear is a no-op. This is not flagged; the bench asserts it never happens.
- ALU writeback to a pending rd cannot occur legally (WAW stall). The bench asserts it.

## Timing
- Writeback: zero latency, combinational grant to the write port. The data is in the register file at the next clk_i edge.
- Scoreboard set/clear take effect on the next edge. The same-cycle clear is bypassed into the stall logic.
- Forced long grant after exactly MaxWait consecutive denied cycles. The grant occurs in cycle MaxWait+1 of waiting.
- Reset (async, any time): pending=0, wait_cnt=0. With inputs idle the outputs are issue_stall_o=0, alu_ready_o=1, long_ready_o=1, rd_we_o=0, pending_o=0.
- Mid-operation reset discards in-flight scoreboard entries. Upstream units must reset too.
- Handshake: requesters hold valid/addr/data stable until ready. Data is consumed on the cycle valid & ready is high.

## Structure
- panda_pkg: MaxWait default constant.
- panda_pkg: typedef wb_req_t {addr, data} shared with the ALU and LSU/MDU writeback stages.
- Sub-module panda_scoreboard: pending flops, set/clear decode, effective-pending bypass, stall compare.
- The arbiter plus wait counter stay in panda_writeback_arbiter.

## Test plan
- Reset, idle → all outputs at reset values; pending_o=0.
- Issue long load rd=5; next cycle issue add with rs1=5 → stall asserted. Then long writeback rd=5 data 0xCAFE → stall drops that same cycle, rd_we_o=1, rd_addr_o=5, pending[5]=0 next cycle.
- alu_valid_i and long_valid_i both high continuously, MaxWait=4 → ALU granted 4 cycles, long granted cycle 5, alu_ready_o=0 that cycle, wait_cnt back to 0.
- Issue long with rd=0 → pending stays 0. Issue with rd=7 while pending[7] (WAW) → stall. Same-cycle clear of 7 with new long issue to 7 → pending[7] remains 1.
- Both valids low, alu_valid_i only, long_valid_i only → correct single grant; rd_we_o=0 when idle.
- Assert rst_ni low while pending[3]=1 and wait_cnt=2 → immediately pending=0, wait_cnt=0, outputs at reset values.
